// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 800x600@60 timing constants, err_flags bit indices, monitor types
// Shared by the timing monitor, its expected-field generator and benches.
package vga_pkg;

  // 800x600@60, 40 MHz pixel clock
  localparam int H_TOTAL  = 1056;
  localparam int H_ACTIVE = 800;
  localparam int HS_START = 840;
  localparam int HS_END   = 968;
  localparam int V_TOTAL  = 628;
  localparam int V_ACTIVE = 600;
  localparam int VS_START = 601;
  localparam int VS_END   = 605;
  localparam bit SYNC_POL = 1'b1;

  // err_flags bit positions
  localparam int ERR_HCNT  = 0;
  localparam int ERR_VCNT  = 1;
  localparam int ERR_HBLNK = 2;
  localparam int ERR_HSYNC = 3;
  localparam int ERR_VBLNK = 4;
  localparam int ERR_VSYNC = 5;
  localparam int ERR_RGB   = 6;
  localparam int ERR_W     = 7;

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_TRACK   = 1'b1
  } mon_state_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_sample_t;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA pixel bus with driver and monitor views
// vga_out: driven by a draw stage; vga_in: observed by sinks and monitors.
interface vga_if;

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport vga_out (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport vga_in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);

endinterface

// File: rtl/vga_expected_gen.sv
// rtl/vga_expected_gen.sv - combinational map from counters to expected blank/sync levels
// Ports: hcount/vcount in; hblnk/hsync/vblnk/vsync out (sync at SYNC_POL inside pulse).
module vga_expected_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int HS_START = vga_pkg::HS_START,
  parameter int HS_END   = vga_pkg::HS_END,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int VS_START = vga_pkg::VS_START,
  parameter int VS_END   = vga_pkg::VS_END,
  parameter bit SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic        hblnk,
  output logic        hsync,
  output logic        vblnk,
  output logic        vsync
);

  localparam logic [10:0] HA  = 11'(H_ACTIVE);
  localparam logic [10:0] HSS = 11'(HS_START);
  localparam logic [10:0] HSE = 11'(HS_END);
  localparam logic [10:0] VA  = 11'(V_ACTIVE);
  localparam logic [10:0] VSS = 11'(VS_START);
  localparam logic [10:0] VSE = 11'(VS_END);

  always_comb begin
    hblnk = (hcount >= HA);
    vblnk = (vcount >= VA);
    hsync = ((hcount >= HSS) && (hcount < HSE)) ? SYNC_POL : !SYNC_POL;
    vsync = ((vcount >= VSS) && (vcount < VSE)) ? SYNC_POL : !SYNC_POL;
  end

endmodule

// File: rtl/vga_timing_monitor.sv
// rtl/vga_timing_monitor.sv - passive VGA timing checker with lock, sticky errors and frame count
// Ports: clk, rst (sync, active high), in (vga_if.vga_in), err_clr;
//        locked, err_flags[6:0], err_cnt[7:0], frame_cnt[15:0], frame_done.
module vga_timing_monitor
  import vga_pkg::*;
#(
  parameter int H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int HS_START = vga_pkg::HS_START,
  parameter int HS_END   = vga_pkg::HS_END,
  parameter int V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int VS_START = vga_pkg::VS_START,
  parameter int VS_END   = vga_pkg::VS_END,
  parameter bit SYNC_POL = vga_pkg::SYNC_POL
) (
  input  logic              clk,
  input  logic              rst,
  vga_if.vga_in             in,
  input  logic              err_clr,
  output logic              locked,
  output logic [ERR_W-1:0]  err_flags,
  output logic [7:0]        err_cnt,
  output logic [15:0]       frame_cnt,
  output logic              frame_done
);

  // 12-bit compares so an 11-bit count of 2047 cannot alias to 0 on +1
  localparam logic [11:0] HT      = 12'(H_TOTAL);
  localparam logic [11:0] HT_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] VT      = 12'(V_TOTAL);
  localparam logic [11:0] VT_LAST = 12'(V_TOTAL - 1);

  vga_sample_t  s;
  logic         s_valid;   // S holds a real bus sample, not the reset value
  logic [10:0]  p_hcount;
  logic [10:0]  p_vcount;

  mon_state_t   state;
  mon_state_t   next_state;

  logic         hblnk_e;
  logic         hsync_e;
  logic         vblnk_e;
  logic         vsync_e;
  logic [11:0]  s_h;
  logic [11:0]  s_v;
  logic [11:0]  h_e;
  logic [11:0]  v_e;
  logic [ERR_W-1:0] mism;
  logic         do_err;
  logic         do_frame;

  // Stage 1: sample register S and previous sample P
  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= '0;
      s_valid  <= 1'b0;
      p_hcount <= '0;
      p_vcount <= '0;
    end else begin
      s        <= '{hcount: in.hcount, vcount: in.vcount, hsync: in.hsync,
                    hblnk: in.hblnk, vsync: in.vsync, vblnk: in.vblnk, rgb: in.rgb};
      s_valid  <= 1'b1;
      p_hcount <= s.hcount;
      p_vcount <= s.vcount;
    end
  end

  vga_expected_gen #(
    .H_ACTIVE (H_ACTIVE),
    .HS_START (HS_START),
    .HS_END   (HS_END),
    .V_ACTIVE (V_ACTIVE),
    .VS_START (VS_START),
    .VS_END   (VS_END),
    .SYNC_POL (SYNC_POL)
  ) u_expected (
    .hcount (s.hcount),
    .vcount (s.vcount),
    .hblnk  (hblnk_e),
    .hsync  (hsync_e),
    .vblnk  (vblnk_e),
    .vsync  (vsync_e)
  );

  // Stage 2: mismatch vector for the sample in S
  always_comb begin
    s_h = {1'b0, s.hcount};
    s_v = {1'b0, s.vcount};
    h_e = ({1'b0, p_hcount} == HT_LAST) ? 12'd0 : {1'b0, p_hcount} + 12'd1;
    if ({1'b0, p_hcount} == HT_LAST) begin
      v_e = ({1'b0, p_vcount} == VT_LAST) ? 12'd0 : {1'b0, p_vcount} + 12'd1;
    end else begin
      v_e = {1'b0, p_vcount};
    end

    mism            = '0;
    mism[ERR_HCNT]  = (s_h != h_e) || (s_h >= HT);
    mism[ERR_VCNT]  = (s_v != v_e) || (s_v >= VT);
    mism[ERR_HBLNK] = (s.hblnk != hblnk_e);
    mism[ERR_HSYNC] = (s.hsync != hsync_e);
    mism[ERR_VBLNK] = (s.vblnk != vblnk_e);
    mism[ERR_VSYNC] = (s.vsync != vsync_e);
    mism[ERR_RGB]   = (s.hblnk || s.vblnk) && (s.rgb != 12'h000);
  end

  // FSM next state and check qualifiers
  always_comb begin
    next_state = state;
    do_err     = 1'b0;
    do_frame   = 1'b0;
    case (state)
      ST_ACQUIRE: begin
        if (s_valid && (s.hcount == 11'd0) && (s.vcount == 11'd0)) begin
          next_state = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (|mism) begin
          do_err     = 1'b1;
          next_state = ST_ACQUIRE;
        end else if ((s_h == HT_LAST) && (s_v == VT_LAST)) begin
          do_frame = 1'b1;
        end
      end
      default: next_state = ST_ACQUIRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACQUIRE;
    end else begin
      state <= next_state;
    end
  end

  assign locked = (state == ST_TRACK);

  // Error and frame bookkeeping; a new error in the err_clr cycle wins
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flags  <= '0;
      err_cnt    <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= do_frame;
      if (do_frame && (frame_cnt != 16'hFFFF)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (do_err) begin
        err_flags <= (err_clr ? '0 : err_flags) | mism;
        if (err_clr) begin
          err_cnt <= 8'd1;
        end else if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end else if (err_clr) begin
        err_flags <= '0;
        err_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb/tb_vga_timing_monitor.sv - directed self-checking bench for vga_timing_monitor
module tb_vga_timing_monitor;

  // Reduced timing keeps whole frames cheap; same structure as 800x600
  localparam int HT  = 48;
  localparam int HA  = 32;
  localparam int HSS = 36;
  localparam int HSE = 40;
  localparam int VT  = 12;
  localparam int VA  = 8;
  localparam int VSS = 9;
  localparam int VSE = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic        locked;
  logic [6:0]  err_flags;
  logic [7:0]  err_cnt;
  logic [15:0] frame_cnt;
  logic        frame_done;

  vga_if bus();

  vga_timing_monitor #(
    .H_TOTAL  (HT),
    .H_ACTIVE (HA),
    .HS_START (HSS),
    .HS_END   (HSE),
    .V_TOTAL  (VT),
    .V_ACTIVE (VA),
    .VS_START (VSS),
    .VS_END   (VSE),
    .SYNC_POL (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (bus),
    .err_clr    (err_clr),
    .locked     (locked),
    .err_flags  (err_flags),
    .err_cnt    (err_cnt),
    .frame_cnt  (frame_cnt),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int ch = 0;
  int cv = 0;
  int fd_count = 0;
  int lock_at  = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference generator: clean bus fields for a position
  task automatic set_bus(input int h, input int v);
    bus.hcount = 11'(h);
    bus.vcount = 11'(v);
    bus.hblnk  = (h >= HA);
    bus.vblnk  = (v >= VA);
    bus.hsync  = (h >= HSS) && (h < HSE);
    bus.vsync  = (v >= VSS) && (v < VSE);
    bus.rgb    = ((h >= HA) || (v >= VA)) ? 12'h000 : 12'h5A5;
  endtask

  task automatic adv();
    ch++;
    if (ch == HT) begin
      ch = 0;
      cv++;
      if (cv == VT) cv = 0;
    end
  endtask

  task automatic run_clean(input int n);
    for (int i = 0; i < n; i++) begin
      set_bus(ch, cv);
      tick();
      if (frame_done) fd_count++;
      adv();
    end
  endtask

  // Drive clean samples until (h,v) is the next position to be driven
  task automatic run_to(input int h, input int v);
    for (int i = 0; i < 2 * HT * VT; i++) begin
      if (ch == h && cv == v) break;
      run_clean(1);
    end
  endtask

  initial begin
    rst     = 1'b1;
    err_clr = 1'b0;
    set_bus(0, 0);
    repeat (3) tick();
    check("rst_locked",     32'(locked),     32'd0);
    check("rst_err_flags",  32'(err_flags),  32'd0);
    check("rst_err_cnt",    32'(err_cnt),    32'd0);
    check("rst_frame_cnt",  32'(frame_cnt),  32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Three clean frames
    ch = 0; cv = 0;
    for (int i = 0; i < 3 * HT * VT + 2; i++) begin
      set_bus(ch, cv);
      tick();
      if (frame_done) fd_count++;
      if (locked && lock_at < 0) lock_at = i;
      adv();
    end
    check("lock_within_frame", 32'((lock_at >= 0) && (lock_at < HT * VT)), 32'd1);
    check("clean_fd_pulses",   32'(fd_count),  32'd3);
    check("clean_frame_cnt",   32'(frame_cnt), 32'd3);
    check("clean_err_flags",   32'(err_flags), 32'd0);
    check("clean_err_cnt",     32'(err_cnt),   32'd0);
    check("clean_locked",      32'(locked),    32'd1);

    // Skipped pixel 16 -> 18
    run_to(17, 0);
    ch = 18;
    set_bus(ch, cv);
    tick();
    adv();
    check("skip_lock_hold",   32'(locked),    32'd1);
    check("skip_flags_hold",  32'(err_flags), 32'd0);
    run_clean(1);
    check("skip_err_flags",   32'(err_flags), 32'h01);
    check("skip_err_cnt",     32'(err_cnt),   32'd1);
    check("skip_locked",      32'(locked),    32'd0);
    run_to(0, 0);
    run_clean(2);
    check("skip_relock",      32'(locked),    32'd1);
    check("skip_frame_cnt",   32'(frame_cnt), 32'd3);
    err_clr = 1'b1;
    run_clean(1);
    err_clr = 1'b0;
    check("clr1_err_flags",   32'(err_flags), 32'd0);
    check("clr1_err_cnt",     32'(err_cnt),   32'd0);

    // Wrong hsync plus rgb in blanking at the same sample
    run_to(HSS, 0);
    set_bus(ch, cv);
    bus.hsync = 1'b0;
    bus.rgb   = 12'hF00;
    tick();
    adv();
    run_clean(1);
    check("sync_rgb_err_flags", 32'(err_flags), 32'h48);
    check("sync_rgb_err_cnt",   32'(err_cnt),   32'd1);
    check("sync_rgb_locked",    32'(locked),    32'd0);
    err_clr = 1'b1;
    run_clean(1);
    err_clr = 1'b0;
    check("clr2_err_flags",   32'(err_flags), 32'd0);
    check("clr2_err_cnt",     32'(err_cnt),   32'd0);

    // Vertical wrap corrupted: 11 -> 12 instead of 0
    run_to(0, 0);
    run_clean(2);
    run_to(HT - 1, VT - 1);
    run_clean(1);
    for (int h = 0; h < HT; h++) begin
      set_bus(h, VT);
      tick();
      if (h == 0) check("vwrap_prev_frame_done", 32'(frame_done), 32'd1);
      if (h == 1) begin
        check("vwrap_err_flags", 32'(err_flags), 32'h02);
        check("vwrap_err_cnt",   32'(err_cnt),   32'd1);
        check("vwrap_locked",    32'(locked),    32'd0);
      end
    end
    ch = 0; cv = 0;
    run_clean(2);
    check("vwrap_frame_cnt", 32'(frame_cnt), 32'd4);
    check("vwrap_relock",    32'(locked),    32'd1);

    // err_clr colliding with a vblnk error
    run_to(5, 3);
    set_bus(ch, cv);
    bus.vblnk = 1'b1;
    bus.rgb   = 12'h000;
    tick();
    adv();
    err_clr = 1'b1;
    run_clean(1);
    err_clr = 1'b0;
    check("collide_err_flags", 32'(err_flags), 32'h10);
    check("collide_err_cnt",   32'(err_cnt),   32'd1);
    err_clr = 1'b1;
    run_clean(1);
    err_clr = 1'b0;
    check("clr3_err_flags",  32'(err_flags), 32'd0);
    check("clr3_err_cnt",    32'(err_cnt),   32'd0);
    check("clr3_frame_cnt",  32'(frame_cnt), 32'd4);

    // Saturation: lock on (0,0), fail on (5,0), repeat
    for (int i = 0; i < 300; i++) begin
      set_bus(0, 0);
      tick();
      if (i == 10)  check("sat_cnt_10",  32'(err_cnt), 32'd10);
      if (i == 255) check("sat_cnt_255", 32'(err_cnt), 32'd255);
      set_bus(5, 0);
      tick();
    end
    set_bus(0, 0);
    tick();
    check("sat_err_cnt",   32'(err_cnt),   32'd255);
    check("sat_err_flags", 32'(err_flags), 32'h01);

    // Reset in the middle of a frame
    ch = 1; cv = 0;
    run_to(20, 6);
    check("pre_rst_locked", 32'(locked), 32'd1);
    set_bus(ch, cv);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    adv();
    check("midrst_locked",     32'(locked),     32'd0);
    check("midrst_err_flags",  32'(err_flags),  32'd0);
    check("midrst_err_cnt",    32'(err_cnt),    32'd0);
    check("midrst_frame_cnt",  32'(frame_cnt),  32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    run_clean(3);
    check("midrst_no_lock",    32'(locked),     32'd0);
    run_to(0, 0);
    run_clean(2);
    check("midrst_relock",     32'(locked),     32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
